// File: rtl/timer_counter.sv
// Programmable up/down step counter with prescaler, limit
// detection, pause/resume and optional auto-reload.
//
// Ports:
//   clk        : clock, all state changes on rising edge
//   arst_n     : asynchronous reset, active-low
//   srst       : synchronous clear, active-high
//   start      : start / resume / restart
//   pause      : pause a running count
//   dir        : 0 = count up, 1 = count down
//   load_en    : load load_value into count and reload
//   load_value : value written by load_en
//   limit      : terminal value, sampled every cycle
//   count      : registered count
//   tick       : one-cycle pulse on every step
//   tc         : one-cycle pulse on the step reaching limit
//   state      : IDLE=0, RUN=1, PAUSE=2, DONE=3
//   busy       : high in RUN or PAUSE
module timer_counter #(
   parameter int COUNTER_BITS  = 8,
   parameter int PRESCALE      = 1,
   parameter int INITIAL_VALUE = 0,
   parameter int WRAP          = 0
) (
   input  logic                    clk,
   input  logic                    arst_n,
   input  logic                    srst,
   input  logic                    start,
   input  logic                    pause,
   input  logic                    dir,
   input  logic                    load_en,
   input  logic [COUNTER_BITS-1:0] load_value,
   input  logic [COUNTER_BITS-1:0] limit,
   output logic [COUNTER_BITS-1:0] count,
   output logic                    tick,
   output logic                    tc,
   output logic [1:0]              state,
   output logic                    busy
);

   localparam int PW =
      (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   localparam logic [COUNTER_BITS-1:0] INIT =
      COUNTER_BITS'(INITIAL_VALUE);

   localparam logic [PW-1:0] PRE_LAST =
      PW'(PRESCALE - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                  st;
   logic [COUNTER_BITS-1:0] reload;
   logic [PW-1:0]           presc;
   logic [COUNTER_BITS-1:0] nxt;
   logic                    presc_end;
   logic                    at_limit;

   // Candidate next value; natural modulo 2^W wrap.
   assign nxt = dir ? (count - COUNTER_BITS'(1))
                    : (count + COUNTER_BITS'(1));

   assign presc_end = (presc == PRE_LAST);
   assign at_limit  = (count == limit);

   assign state = st;
   assign busy  = (st == RUN) || (st == PAUSE);

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         count  <= INIT;
         reload <= INIT;
         presc  <= '0;
         st     <= IDLE;
         tick   <= 1'b0;
         tc     <= 1'b0;
      end else begin
         tick <= 1'b0;
         tc   <= 1'b0;
         if (srst) begin
            count  <= INIT;
            reload <= INIT;
            presc  <= '0;
            st     <= IDLE;
         end else if (load_en) begin
            count  <= load_value;
            reload <= load_value;
            presc  <= '0;
            st     <= IDLE;
         end else begin
            unique case (st)
               IDLE: begin
                  // Starting on limit finishes at once, silently.
                  if (start)
                     st <= at_limit ? DONE : RUN;
               end
               RUN: begin
                  if (pause) begin
                     st <= PAUSE;
                  end else if (presc_end) begin
                     presc <= '0;
                     tick  <= 1'b1;
                     if ((WRAP != 0) && at_limit) begin
                        // Step away from limit reloads.
                        count <= reload;
                     end else begin
                        count <= nxt;
                        if (nxt == limit) begin
                           tc <= 1'b1;
                           if (WRAP == 0)
                              st <= DONE;
                        end
                     end
                  end else begin
                     presc <= presc + PW'(1);
                  end
               end
               PAUSE: begin
                  // Prescaler keeps its held phase.
                  if (start)
                     st <= RUN;
               end
               DONE: begin
                  if (start) begin
                     count <= reload;
                     presc <= '0;
                     st    <= RUN;
                  end
               end
               default: st <= IDLE;
            endcase
         end
      end
   end

endmodule
